// File: rtl/saper_pkg.sv
// Shared types and helpers for the mine-reveal sequencing slice.
package saper_pkg;

  localparam int IDX_W = 5;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CHK,
    SYNC,
    DWELL,
    ADV,
    FIN
  } state_t;

  // Board side length for a game level; level 0 means no board.
  function automatic logic [IDX_W-1:0] board_side(input logic [1:0] level);
    case (level)
      2'd1:    return 5'd8;
      2'd2:    return 5'd16;
      2'd3:    return 5'd24;
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/mine_reveal_ctrl_if.sv
// Mine map read port: strobe plus 1-based cell address, data one cycle later.
interface mine_reveal_ctrl_if;
  import saper_pkg::*;

  logic             mine_rd_en;
  logic [IDX_W-1:0] mine_rd_x;
  logic [IDX_W-1:0] mine_rd_y;
  logic             mine_rd_data;

  modport master (output mine_rd_en, mine_rd_x, mine_rd_y, input mine_rd_data);
  modport slave  (input mine_rd_en, mine_rd_x, mine_rd_y, output mine_rd_data);
endinterface

// File: rtl/vsync_edge_det.sv
// Frame boundary detector: one-cycle pulse on each rising edge of vsync.
module vsync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  output logic vs_rise
);

  logic vsync_q;

  // Previous-cycle copy of vsync.
  always_ff @(posedge clk) begin
    if (!rst_n) vsync_q <= 1'b0;
    else        vsync_q <= vsync;
  end

  assign vs_rise = vsync & ~vsync_q;

endmodule

// File: rtl/mine_reveal_ctrl.sv
// Game-over mine reveal sequencer. Scans the mine map row by row and shows
// each mine to the drawing stage for DWELL_FRAMES frames, changing the
// displayed position only on frame boundaries.
// Optional build macro MINE_REVEAL_LOOP_EN: after the last cell, wait one
// frame edge and rescan from (1,1) forever (busy and done stay high) until
// reset or level == 0.
//
// state | meaning
// IDLE  | waiting for start with a non-zero level
// RD    | mine map read strobe for current scan cell
// CHK   | read data valid; mine -> SYNC, empty -> ADV
// SYNC  | mine found, waiting for a frame edge to present it
// DWELL | mine displayed, counting frame edges
// ADV   | step to next cell, or finish after (N,N)
// FIN   | board scanned; last mine stays drawn
module mine_reveal_ctrl
  import saper_pkg::*;
#(
  parameter int DWELL_FRAMES = 8,
  parameter int FRM_W        = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            level,
  input  logic                  start,
  input  logic                  vsync,
  mine_reveal_ctrl_if.master    mem,
  output logic [IDX_W-1:0]      mine_ind_x,
  output logic [IDX_W-1:0]      mine_ind_y,
  output logic                  explode,
  output logic                  busy,
  output logic                  done,
  output logic [9:0]            mines_shown
);

  localparam logic [FRM_W-1:0] DWELL_LAST = FRM_W'(DWELL_FRAMES - 1);
  localparam logic [9:0]       SHOWN_MAX  = 10'h3FF;

  state_t           state;
  logic [IDX_W-1:0] side;
  logic [IDX_W-1:0] scan_x;
  logic [IDX_W-1:0] scan_y;
  logic [FRM_W-1:0] frm_cnt;
  logic             vs_rise;
  logic             start_ok;
  logic             launch;
  logic             abort;

  vsync_edge_det u_vs_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .vsync   (vsync),
    .vs_rise (vs_rise)
  );

  assign start_ok      = start && (level != 2'd0);
  assign mem.mine_rd_x = scan_x;
  assign mem.mine_rd_y = scan_y;

`ifdef MINE_REVEAL_LOOP_EN
  // A looping reveal never finishes on its own; only level 0 stops it.
  assign launch = start_ok && (state == IDLE);
  assign abort  = (state != IDLE) && (level == 2'd0);
`else
  assign launch = start_ok && ((state == IDLE) || (state == FIN));
  assign abort  = 1'b0;
`endif

  // Reveal sequencer: scan, frame-aligned display, dwell and completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      side           <= '0;
      scan_x         <= '0;
      scan_y         <= '0;
      frm_cnt        <= '0;
      mem.mine_rd_en <= 1'b0;
      mine_ind_x     <= '0;
      mine_ind_y     <= '0;
      explode        <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      mines_shown    <= '0;
    end else begin
      mem.mine_rd_en <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        explode <= 1'b0;
        busy    <= 1'b0;
      end else if (launch) begin
        side           <= board_side(level);
        scan_x         <= IDX_W'(1);
        scan_y         <= IDX_W'(1);
        mines_shown    <= '0;
        done           <= 1'b0;
        explode        <= 1'b0;
        busy           <= 1'b1;
        mem.mine_rd_en <= 1'b1;
        state          <= RD;
      end else begin
        case (state)
          IDLE: ;
          RD:   state <= CHK;
          CHK:  state <= mem.mine_rd_data ? SYNC : ADV;
          SYNC: begin
            // The new position lands exactly on a frame boundary.
            if (vs_rise) begin
              mine_ind_x <= scan_x;
              mine_ind_y <= scan_y;
              explode    <= 1'b1;
              if (mines_shown != SHOWN_MAX) mines_shown <= mines_shown + 1'b1;
              frm_cnt    <= '0;
              state      <= DWELL;
            end
          end
          DWELL: begin
            if (vs_rise) begin
              if (frm_cnt == DWELL_LAST) state <= ADV;
              else                       frm_cnt <= frm_cnt + 1'b1;
            end
          end
          ADV: begin
            if (scan_x == side) begin
              if (scan_y == side) begin
                done  <= 1'b1;
`ifndef MINE_REVEAL_LOOP_EN
                busy  <= 1'b0;
`endif
                state <= FIN;
              end else begin
                scan_x         <= IDX_W'(1);
                scan_y         <= scan_y + 1'b1;
                mem.mine_rd_en <= 1'b1;
                state          <= RD;
              end
            end else begin
              scan_x         <= scan_x + 1'b1;
              mem.mine_rd_en <= 1'b1;
              state          <= RD;
            end
          end
          FIN: begin
`ifdef MINE_REVEAL_LOOP_EN
            if (vs_rise) begin
              scan_x         <= IDX_W'(1);
              scan_y         <= IDX_W'(1);
              mem.mine_rd_en <= 1'b1;
              state          <= RD;
            end
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mine_reveal_ctrl.sv
// Self-checking bench for mine_reveal_ctrl: random mine maps and frame
// lengths, compared against a row-major list of expected mine displays.
module tb_mine_reveal_ctrl;
  import saper_pkg::*;

  localparam int DWELL = 2;

  typedef struct { int x; int y; int rise; } evt_t;
  typedef struct { int x; int y; } xy_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] level = 2'd0;
  logic       start = 1'b0;
  logic       vsync = 1'b0;
  logic [4:0] ind_x, ind_y;
  logic       explode, busy, done;
  logic [9:0] mines_shown;

  mine_reveal_ctrl_if mem_if ();

  mine_reveal_ctrl #(.DWELL_FRAMES(DWELL), .FRM_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .level       (level),
    .start       (start),
    .vsync       (vsync),
    .mem         (mem_if.master),
    .mine_ind_x  (ind_x),
    .mine_ind_y  (ind_y),
    .explode     (explode),
    .busy        (busy),
    .done        (done),
    .mines_shown (mines_shown)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  bit   mine_map [32][32];
  int   frame_len = 20;
  int   fcnt = 0;
  logic pend = 1'b0;

  // bench-side view of each clock edge
  logic tb_vs_q = 1'b0, tb_rise = 1'b0, tb_rst_edge = 1'b1;

  evt_t evt_log[$];
  xy_t  rd_log[$];
  int   rise_cnt = 0;
  int   ind_bad = 0;
  int   expl_drop = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial forever #5 clk = ~clk;

  initial begin
    #950000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  // vsync: high for the first 3 cycles of each frame
  initial forever begin
    @(negedge clk);
    fcnt  = (fcnt + 1 >= frame_len) ? 0 : fcnt + 1;
    vsync = (fcnt < 3);
  end

  // mine map memory: data valid the cycle after the strobe
  initial forever begin
    @(negedge clk);
    mem_if.mine_rd_data = pend;
    pend = mem_if.mine_rd_en ? mine_map[mem_if.mine_rd_y][mem_if.mine_rd_x] : 1'b0;
  end

  always @(posedge clk) begin
    tb_rise     <= vsync & ~tb_vs_q;
    tb_vs_q     <= vsync;
    tb_rst_edge <= ~rst_n;
  end

  // observer: read log, mine display events, frame-alignment violations
  initial begin
    logic [4:0] p_x, p_y;
    logic       p_expl, p_busy;
    logic [9:0] p_ms;
    p_x = '0; p_y = '0; p_expl = 1'b0; p_busy = 1'b0; p_ms = '0;
    forever begin
      @(negedge clk);
      if (tb_rise) rise_cnt++;
      if (mem_if.mine_rd_en === 1'b1)
        rd_log.push_back('{x: int'(mem_if.mine_rd_x), y: int'(mem_if.mine_rd_y)});
      if (!tb_rst_edge) begin
        if ((ind_x != p_x || ind_y != p_y) && !tb_rise) ind_bad++;
        if (p_expl && !explode && p_busy && busy) expl_drop++;
        if (mines_shown != p_ms && mines_shown != 10'd0) begin
          if (!explode) ind_bad++;
          evt_log.push_back('{x: int'(ind_x), y: int'(ind_y), rise: rise_cnt});
        end
      end
      p_x = ind_x; p_y = ind_y; p_expl = explode; p_busy = busy; p_ms = mines_shown;
    end
  end

  task automatic clear_map();
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++)
        mine_map[y][x] = 1'b0;
  endtask

  task automatic random_map(input int n, input int one_in);
    clear_map();
    for (int y = 1; y <= n; y++)
      for (int x = 1; x <= n; x++)
        mine_map[y][x] = ($urandom_range(1, one_in) == 1);
  endtask

  // One full reveal compared against the row-major list of mines.
  task automatic run_scan(input int lvl, input bit extra);
    int   n, r0, e0, lat, budget, bad, cnt;
    bit   expl_seen;
    evt_t exp_q[$];
    n = lvl * 8;
    for (int y = 1; y <= n; y++)
      for (int x = 1; x <= n; x++)
        if (mine_map[y][x]) exp_q.push_back('{x: x, y: y, rise: 0});
    budget = 3 * n * n + (exp_q.size() + 1) * frame_len * (DWELL + 2) + 50;
    r0 = rd_log.size();
    e0 = evt_log.size();
    expl_seen = 1'b0;
    @(negedge clk);
    level = 2'(lvl);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    level = 2'($urandom_range(1, 3));
    lat = 1;
    while (!done && lat < budget) begin
      @(negedge clk);
      lat++;
      if (explode) expl_seen = 1'b1;
      start = extra && busy && ($urandom_range(0, 40) == 0);
    end
    start = 1'b0;
    #1;
    check_val("done_reached", done, 1);
    check_val("busy_at_fin", busy, 0);
    if (exp_q.size() == 0) begin
      check_val("empty_latency", lat + 1, 3 * n * n + 2);
      check_val("expl_never", expl_seen, 0);
    end
    check_val("rd_count", rd_log.size() - r0, n * n);
    bad = 0;
    cnt = (rd_log.size() - r0 < n * n) ? rd_log.size() - r0 : n * n;
    for (int i = 0; i < cnt; i++)
      if (rd_log[r0 + i].x != (i % n) + 1 || rd_log[r0 + i].y != (i / n) + 1) bad++;
    check_val("rd_order", bad, 0);
    check_val("mine_count", evt_log.size() - e0, exp_q.size());
    cnt = (evt_log.size() - e0 < exp_q.size()) ? evt_log.size() - e0 : exp_q.size();
    for (int i = 0; i < cnt; i++) begin
      check_val("mine_x", evt_log[e0 + i].x, exp_q[i].x);
      check_val("mine_y", evt_log[e0 + i].y, exp_q[i].y);
      if (i > 0)
        check_val("dwell_gap", (evt_log[e0 + i].rise - evt_log[e0 + i - 1].rise) >= DWELL + 1, 1);
    end
    check_val("mines_shown", mines_shown, exp_q.size());
    check_val("expl_final", explode, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      check_val("last_x", ind_x, exp_q[exp_q.size() - 1].x);
      check_val("last_y", ind_y, exp_q[exp_q.size() - 1].y);
      if (cnt == exp_q.size() && exp_q[exp_q.size() - 1].x == n && exp_q[exp_q.size() - 1].y == n)
        check_val("last_dwell", rise_cnt - evt_log[evt_log.size() - 1].rise, DWELL);
    end
    check_val("ind_on_vsync", ind_bad, 0);
    check_val("expl_held", expl_drop, 0);
  endtask

  task automatic start_level0();
    int r0;
    bit busy_seen;
    r0 = rd_log.size();
    busy_seen = 1'b0;
    @(negedge clk);
    level = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    #1;
    check_val("lvl0_no_read", rd_log.size() - r0, 0);
    check_val("lvl0_no_busy", busy_seen, 0);
  endtask

  initial begin
    int k, e0;
    clear_map();
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_explode", explode, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_shown", mines_shown, 0);
    check_val("rst_rd_en", mem_if.mine_rd_en, 0);
    check_val("rst_ind", {ind_x, ind_y}, 0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef MINE_REVEAL_LOOP_EN
    mine_map[24][24] = 1'b1;
    frame_len = 20;
    e0 = evt_log.size();
    @(negedge clk);
    level = 2'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (evt_log.size() - e0 < 3 && k < 20000) begin
      @(negedge clk);
      k++;
    end
    #1;
    check_val("loop_passes", evt_log.size() - e0 >= 3, 1);
    for (int i = e0; i < evt_log.size(); i++) begin
      check_val("loop_x", evt_log[i].x, 24);
      check_val("loop_y", evt_log[i].y, 24);
    end
    check_val("loop_done", done, 1);
    check_val("loop_busy", busy, 1);
    check_val("loop_shown", mines_shown, evt_log.size() - e0);
    @(negedge clk);
    level = 2'd0;
    @(negedge clk);
    #1;
    check_val("loop_stop_busy", busy, 0);
    check_val("loop_stop_expl", explode, 0);
    check_val("ind_on_vsync", ind_bad, 0);
`else
    start_level0();

    // directed: two mines, the last at the corner
    clear_map();
    mine_map[1][3] = 1'b1;
    mine_map[8][8] = 1'b1;
    frame_len = 20;
    run_scan(1, 1'b0);

    // start ignored while done holds; then restart from FIN
    start_level0();
    #1;
    check_val("fin_done_hold", done, 1);

    // empty board timing
    clear_map();
    run_scan(2, 1'b0);

    // same map with and without extra starts while busy
    random_map(8, 6);
    mine_map[8][8] = 1'b1;
    frame_len = 13;
    run_scan(1, 1'b0);
    run_scan(1, 1'b1);

    // randomized boards and frame lengths
    for (int r = 0; r < 5; r++) begin
      k = $urandom_range(1, 3);
      random_map(k * 8, 24);
      frame_len = $urandom_range(8, 30);
      run_scan(k, $urandom_range(0, 1));
    end

    // reset in the middle of a dwell
    clear_map();
    mine_map[1][2] = 1'b1;
    frame_len = 20;
    @(negedge clk);
    level = 2'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!explode && k < 500) begin
      @(negedge clk);
      k++;
    end
    check_val("expl_before_rst", explode, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("mid_rst_explode", explode, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_shown", mines_shown, 0);
    check_val("mid_rst_done", done, 0);
    check_val("mid_rst_rd_en", mem_if.mine_rd_en, 0);
    start_level0();

    // normal operation resumes after reset
    random_map(8, 10);
    run_scan(1, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
